sevenseg_mux_controller: RTL and testbench

Parametrised multiplexed seven-segment driver. It converts a WIDTH-bit unsigned binary value to DIGITS BCD digits using a sequential double-dabble conversion, one bit per cycle. It then scans the digits onto a shared segment bus with per-digit enables, a programmable dwell time and a dead-time blanking interval. Versus the fixed three-digit controller it adds:
- parametrised width and digit count;
- tear-free atomic display update;
- leading-zero blanking;
- overflow indication;
- glitch-free, registered digit switching.

It sits between game logic, which supplies the score or value, and the top-level display pins.

---
 rtl/sevenseg_mux_controller.sv | 151 +++++++++++++++
 tb/tb_sevenseg_mux_controller.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sevenseg_mux_controller.sv
// sevenseg_mux_controller: serial double-dabble binary-to-BCD converter feeding a
// multiplexed seven-segment scanner with dead time, leading-zero blanking and overflow dash.
module sevenseg_mux_controller #(
    parameter int WIDTH        = 8,
    parameter int DIGITS       = 3,
    parameter int PRESCALE     = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter bit LZB          = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(PRESCALE);
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (WIDTH < 1 || DIGITS < 1 || PRESCALE < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= PRESCALE) begin : g_param_check
        $error("sevenseg_mux_controller: unsupported parameter combination");
    end

    logic [WIDTH-1:0]    r_bin;
    logic [BW-1:0]       r_bcd;
    logic                r_ovf_work;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic [BW-1:0]       r_disp;
    logic                r_ovf;
    logic [PW-1:0]       r_phase;
    logic [SW-1:0]       r_slot;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    logic [BW-1:0]       w_adj;
    logic [BW+WIDTH:0]   w_shift;
    logic [BW-1:0]       w_bcd_nxt;
    logic                w_ovf_nxt;
    logic                w_last;
    logic [3:0]          w_dig [DIGITS];
    logic [DIGITS-1:0]   w_lz;
    logic [DIGITS-1:0]   w_onehot;
    logic                w_blank;
    logic                w_lzb;
    logic [DIGITS-1:0]   w_an_nxt;
    logic [6:0]          w_seg_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++)
            w_adj[4*i+:4] = (r_bcd[4*i+:4] >= 4'd5) ? r_bcd[4*i+:4] + 4'd3 : r_bcd[4*i+:4];
    end

    // The bit leaving the top nibble is a carry into a digit we do not have.
    assign w_shift   = {w_adj, r_bin, 1'b0};
    assign w_bcd_nxt = w_shift[BW+WIDTH-1:WIDTH];
    assign w_ovf_nxt = r_ovf_work | w_shift[BW+WIDTH];
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_ovf_work <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_disp     <= '0;
            r_ovf      <= 1'b0;
        end else if (r_busy) begin
            r_bin      <= w_shift[WIDTH-1:0];
            r_bcd      <= w_bcd_nxt;
            r_ovf_work <= w_ovf_nxt;
            r_cnt      <= r_cnt + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
                r_disp <= w_bcd_nxt;
                r_ovf  <= w_ovf_nxt;
            end
        end else if (load) begin
            r_bin      <= value;
            r_bcd      <= '0;
            r_ovf_work <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_slot  <= '0;
        end else if (r_phase == PW'(PRESCALE - 1)) begin
            r_phase <= '0;
            r_slot  <= (r_slot == SW'(DIGITS - 1)) ? '0 : r_slot + 1'b1;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    // Digit 0 is the most significant nibble; w_lz[k] means digits 0..k are all zero.
    always_comb begin
        for (int k = 0; k < DIGITS; k++)
            w_dig[k] = r_disp[4*(DIGITS-1-k)+:4];
        w_lz[0] = (w_dig[0] == 4'd0);
        for (int k = 1; k < DIGITS; k++)
            w_lz[k] = w_lz[k-1] && (w_dig[k] == 4'd0);
    end

    assign w_onehot = DIGITS'(1) << r_slot;
    assign w_blank  = int'(r_phase) < BLANK_CYCLES;
    assign w_lzb    = LZB && (int'(r_slot) < DIGITS - 1) && w_lz[r_slot];

    always_comb begin
        w_an_nxt  = w_blank ? '0 : r_ovf ? w_onehot : w_lzb ? '0 : w_onehot;
        w_seg_nxt = w_blank ? 7'h00 : r_ovf ? 7'h40 : w_lzb ? 7'h00 : f_decode(w_dig[r_slot]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= '0;
            r_seg <= '0;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign busy = r_busy;
    assign seg  = r_seg;
    assign an   = r_an;
endmodule

// File: tb/tb_sevenseg_mux_controller.sv
// tb_sevenseg_mux_controller: two differently parameterised instances on shared stimulus,
// checked every cycle against an arithmetic model of value, scan position and display.
module tb_sevenseg_mux_controller;
    localparam int W = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       load  = 1'b0;
    logic [7:0] value = '0;
    logic       busy0, busy1;
    logic [6:0] seg0, seg1;
    logic [2:0] an0;
    logic [1:0] an1;

    int n_checks = 0;
    int n_errors = 0;
    int k, m_cnt, m_disp, m_pend;
    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    sevenseg_mux_controller #(.WIDTH(8), .DIGITS(3), .PRESCALE(8), .BLANK_CYCLES(2), .LZB(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .busy(busy0), .seg(seg0), .an(an0));

    sevenseg_mux_controller #(.WIDTH(8), .DIGITS(2), .PRESCALE(6), .BLANK_CYCLES(0), .LZB(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .busy(busy1), .seg(seg1), .an(an1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // {an, seg} expected after an edge, given the displayed value and edges since reset before it.
    function automatic logic [15:0] f_expect(int v, int n, int d, int p, int b, bit lzb);
        int ph = n % p;
        int sl = (n / p) % d;
        int pw = 10 ** (d - 1 - sl);
        logic [15:0] oh = 16'(1) << sl;
        if (ph < b) return 16'h0;
        if (v >= 10 ** d) return (oh << 7) | 16'h40;
        if (lzb && sl < d - 1 && v / pw == 0) return 16'h0;
        return (oh << 7) | 16'(pat[(v / pw) % 10]);
    endfunction

    task automatic tick;
        logic [15:0] x0, x1;
        @(posedge clk);
        x0 = f_expect(m_disp, k, 3, 8, 2, 1'b1);
        x1 = f_expect(m_disp, k, 2, 6, 0, 1'b0);
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_disp = m_pend;
        end else if (load) begin
            m_pend = value;
            m_cnt  = W;
        end
        k++;
        #1;
        check("seg0", seg0, x0[6:0]);
        check("an0", an0, x0[9:7]);
        check("busy0", busy0, m_cnt > 0);
        check("onehot0", $countones(an0) <= 1, 1);
        check("seg1", seg1, x1[6:0]);
        check("an1", an1, x1[8:7]);
        check("busy1", busy1, m_cnt > 0);
    endtask

    task automatic async_reset;
        rst_n = 1'b0;
        #1;
        check("rst_seg0", seg0, 0);
        check("rst_an0", an0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_seg1", seg1, 0);
        check("rst_an1", an1, 0);
        check("rst_busy1", busy1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        k      = 0;
        m_cnt  = 0;
        m_disp = 0;
    endtask

    task automatic do_load(input int v, input int wait_n);
        value = 8'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (wait_n) tick();
    endtask

    initial begin
        k = 0; m_cnt = 0; m_disp = 0; m_pend = 0;
        #2;
        async_reset();
        repeat (30) tick();
        do_load(255, 40);
        do_load(7, 40);
        do_load(100, 40);
        do_load(99, 40);
        do_load(12, 2);
        do_load(200, 40);
        do_load(0, 30);
        do_load(123, 3);
        #2;
        async_reset();
        repeat (30) tick();
        repeat (200) begin
            value = 8'($urandom_range(0, 255));
            load  = ($urandom_range(0, 5) == 0);
            tick();
        end
        load = 1'b0;
        repeat (30) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
